// File: rtl/wave_capture_pkg.sv
// Shared constants and FSM encoding for the wave_capture block.
package wave_capture_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 9;
  localparam int DEPTH_DEF = 2 ** AW_DEF;
  localparam int PERIOD_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/wave_capture_sample_ram.sv
// Capture buffer: simple dual-port RAM, one write port, registered read-first read port.
module sample_ram #(
  parameter int DW = 8,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Write port and registered read port; a same-address read returns the old word.
  // NOTE: the array has no reset so it maps onto block RAM; rd_data is unknown until first read.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/wave_capture.sv
// Triggered waveform capture: arms, waits for a level crossing, stores 2**AW samples,
// and measures min, max and period of the captured waveform.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       din,
  input  logic                din_vld,
  input  logic                arm,
  input  logic [DW-1:0]       trig_level,
  input  logic                trig_edge,
  output logic                busy,
  output logic                done,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [DW-1:0]       rd_data,
  output logic [DW-1:0]       wave_min,
  output logic [DW-1:0]       wave_max,
  output logic [PERIOD_W-1:0] period,
  output logic                period_vld
);

  state_t              state, state_nxt;
  logic [DW-1:0]       prev;
  logic                prev_ok;
  logic [DW-1:0]       cap_level;
  logic                cap_edge;
  logic [AW-1:0]       wr_ptr;
  logic [PERIOD_W-1:0] cnt;
  logic                arm_ok, trig_hit, recross, wr_en, last_wr;

  // Crossing detection: live threshold while armed, threshold frozen at trigger for the period.
  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    arm_ok   = arm && (state == ST_IDLE || state == ST_DONE);
    trig_hit = din_vld && prev_ok &&
               (trig_edge ? (prev >= trig_level && din < trig_level)
                          : (prev < trig_level && din >= trig_level));
    recross  = din_vld && prev_ok &&
               (cap_edge ? (prev >= cap_level && din < cap_level)
                         : (prev < cap_level && din >= cap_level));
    wr_en    = (state == ST_ARMED && trig_hit) || (state == ST_CAPTURE && din_vld);
    last_wr  = (state == ST_CAPTURE) && din_vld && (&wr_ptr);
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (arm)      state_nxt = ST_ARMED;
      ST_ARMED:   if (trig_hit) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (last_wr)  state_nxt = ST_DONE;
      ST_DONE:    if (arm)      state_nxt = ST_ARMED;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = (state == ST_ARMED) || (state == ST_CAPTURE);
    done = (state == ST_DONE);
  end

  // Datapath: previous sample, write pointer, min/max and period measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      prev_ok    <= 1'b0;
      cap_level  <= '0;
      cap_edge   <= 1'b0;
      wr_ptr     <= '0;
      cnt        <= '0;
      wave_min   <= '0;
      wave_max   <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else if (arm_ok) begin
      prev_ok    <= 1'b0;
      wr_ptr     <= '0;
      cnt        <= '0;
      wave_min   <= '0;
      wave_max   <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      if (din_vld) begin
        prev    <= din;
        prev_ok <= 1'b1;
      end
      if (state == ST_ARMED && trig_hit) begin
        wr_ptr    <= AW'(1);
        cnt       <= PERIOD_W'(1);
        wave_min  <= din;
        wave_max  <= din;
        cap_level <= trig_level;
        cap_edge  <= trig_edge;
      end else if (state == ST_CAPTURE && din_vld) begin
        if (!(&wr_ptr)) wr_ptr <= wr_ptr + 1'b1;
        if (din < wave_min) wave_min <= din;
        if (din > wave_max) wave_max <= din;
        if (recross && !period_vld) begin
          period     <= cnt;
          period_vld <= 1'b1;
        end
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end

  sample_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .re      (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_wave_capture.sv
// Directed-vector bench for wave_capture.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        rst, din_vld, arm, trig_edge, rd_en;
  logic [7:0]  din, trig_level, rd_data, wave_min, wave_max;
  logic [8:0]  rd_addr;
  logic        busy, done, period_vld;
  logic [15:0] period;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  wave_capture dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_vld    (din_vld),
    .arm        (arm),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wave_min   (wave_min),
    .wave_max   (wave_max),
    .period     (period),
    .period_vld (period_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [7:0] d);
    rd_en   = 1'b1;
    rd_addr = 9'(a);
    tick();
    rd_en = 1'b0;
    d     = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (wave_min !== 8'd0 || wave_max !== 8'd0)
      $display("FAIL reset_minmax: got %0d/%0d want 0/0", wave_min, wave_max); else pass_cnt++;
    total_cnt++; if (period !== 16'd0 || period_vld !== 1'b0)
      $display("FAIL reset_period: got %0d/%0b want 0/0", period, period_vld); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sawtooth();
    logic [7:0] d;
    trig_level = 8'd128;
    trig_edge  = 1'b0;
    do_arm();
    total_cnt++; if (busy !== 1'b1) $display("FAIL saw_armed_busy: got %0b want 1", busy); else pass_cnt++;
    for (int i = 0; i < 640; i++) begin
      din     = 8'(i);
      din_vld = 1'b1;
      tick();
      if (i == 638) begin
        total_cnt++; if (done !== 1'b0) $display("FAIL saw_early_done: got %0b want 0", done); else pass_cnt++;
      end
    end
    din_vld = 1'b0;
    total_cnt++; if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL saw_done: got done=%0b busy=%0b want 1/0", done, busy); else pass_cnt++;
    total_cnt++; if (wave_min !== 8'd0 || wave_max !== 8'd255)
      $display("FAIL saw_minmax: got %0d/%0d want 0/255", wave_min, wave_max); else pass_cnt++;
    total_cnt++; if (period !== 16'd256 || period_vld !== 1'b1)
      $display("FAIL saw_period: got %0d/%0b want 256/1", period, period_vld); else pass_cnt++;
    read_word(0, d);
    total_cnt++; if (d !== 8'd128) $display("FAIL saw_addr0: got %0d want 128", d); else pass_cnt++;
    read_word(100, d);
    total_cnt++; if (d !== 8'd228) $display("FAIL saw_addr100: got %0d want 228", d); else pass_cnt++;
    read_word(511, d);
    total_cnt++; if (d !== 8'd127) $display("FAIL saw_addr511: got %0d want 127", d); else pass_cnt++;
  endtask

  task automatic test_falling();
    logic [7:0] d;
    int n = 0;
    trig_level = 8'd100;
    trig_edge  = 1'b1;
    do_arm();
    while (!done && n < 2000) begin
      din     = (((n / 32) % 2) == 0) ? 8'd200 : 8'd0;
      din_vld = 1'b1;
      tick();
      n++;
    end
    din_vld = 1'b0;
    total_cnt++; if (n !== 544) $display("FAIL fall_sample_count: got %0d want 544", n); else pass_cnt++;
    total_cnt++; if (period !== 16'd64 || period_vld !== 1'b1)
      $display("FAIL fall_period: got %0d/%0b want 64/1", period, period_vld); else pass_cnt++;
    total_cnt++; if (wave_min !== 8'd0 || wave_max !== 8'd200)
      $display("FAIL fall_minmax: got %0d/%0d want 0/200", wave_min, wave_max); else pass_cnt++;
    read_word(0, d);
    total_cnt++; if (d !== 8'd0) $display("FAIL fall_addr0: got %0d want 0", d); else pass_cnt++;
    read_word(32, d);
    total_cnt++; if (d !== 8'd200) $display("FAIL fall_addr32: got %0d want 200", d); else pass_cnt++;
  endtask

  task automatic test_no_trigger();
    trig_level = 8'd50;
    trig_edge  = 1'b0;
    do_arm();
    din     = 8'd50;
    din_vld = 1'b1;
    for (int i = 0; i < 600; i++) tick();
    din_vld = 1'b0;
    total_cnt++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL notrig_state: got busy=%0b done=%0b want 1/0", busy, done); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL notrig_reset_busy: got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_sparse();
    logic [7:0] exp_mem [512];
    logic [7:0] v, d;
    int k = 0, t_trig = 0, t_done = -1, errs = 0;
    trig_level = 8'd128;
    trig_edge  = 1'b0;
    do_arm();
    while (k < 600) begin
      v       = (k == 0) ? 8'd10 : (k == 1) ? 8'd200 : 8'(k * 37 + 11);
      din     = v;
      din_vld = 1'b1;
      tick();
      if (k == 1) t_trig = cyc;
      if (k >= 1 && k <= 512) exp_mem[k-1] = v;
      if (done) begin
        t_done = cyc;
        break;
      end
      din_vld = 1'b0;
      din     = 8'hEE;
      tick();
      tick();
      k++;
    end
    din_vld = 1'b0;
    total_cnt++; if (k !== 512) $display("FAIL sparse_last_sample: got %0d want 512", k); else pass_cnt++;
    total_cnt++; if (t_done - t_trig !== 1533)
      $display("FAIL sparse_latency: got %0d want 1533", t_done - t_trig); else pass_cnt++;
    for (int a = 0; a < 512; a++) begin
      read_word(a, d);
      if (d !== exp_mem[a]) begin
        if (errs == 0) $display("FAIL sparse_contents: addr %0d got %0d want %0d", a, d, exp_mem[a]);
        errs++;
      end
    end
    total_cnt++; if (errs !== 0) $display("FAIL sparse_contents_total: got %0d bad words want 0", errs); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int n = 0;
    trig_level = 8'd128;
    trig_edge  = 1'b0;
    do_arm();
    for (int i = 0; i < 428; i++) begin
      din     = 8'(i);
      din_vld = 1'b1;
      tick();
    end
    din_vld = 1'b0;
    total_cnt++; if (period_vld !== 1'b1 || busy !== 1'b1)
      $display("FAIL rmid_pre: got vld=%0b busy=%0b want 1/1", period_vld, busy); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || wave_min !== 8'd0 || wave_max !== 8'd0 ||
                     period !== 16'd0 || period_vld !== 1'b0)
      $display("FAIL rmid_outputs: got busy=%0b done=%0b min=%0d max=%0d period=%0d vld=%0b want all 0",
               busy, done, wave_min, wave_max, period, period_vld); else pass_cnt++;
    do_arm();
    while (!done && n < 2000) begin
      din     = 8'(3 * n);
      din_vld = 1'b1;
      tick();
      n++;
    end
    din_vld = 1'b0;
    total_cnt++; if (n !== 555) $display("FAIL rmid_sample_count: got %0d want 555", n); else pass_cnt++;
    total_cnt++; if (period !== 16'd85 || period_vld !== 1'b1)
      $display("FAIL rmid_period: got %0d/%0b want 85/1", period, period_vld); else pass_cnt++;
    total_cnt++; if (wave_min !== 8'd0 || wave_max !== 8'd255)
      $display("FAIL rmid_minmax: got %0d/%0d want 0/255", wave_min, wave_max); else pass_cnt++;
    read_word(0, d);
    total_cnt++; if (d !== 8'd129) $display("FAIL rmid_addr0: got %0d want 129", d); else pass_cnt++;
    read_word(300, d);
    total_cnt++; if (d !== 8'd5) $display("FAIL rmid_addr300: got %0d want 5", d); else pass_cnt++;
    read_word(511, d);
    total_cnt++; if (d !== 8'd126) $display("FAIL rmid_addr511: got %0d want 126", d); else pass_cnt++;
  endtask

  task automatic test_arm_during_capture();
    logic [7:0] d;
    trig_level = 8'd128;
    trig_edge  = 1'b0;
    do_arm();
    for (int i = 0; i < 640; i++) begin
      din     = 8'(i);
      din_vld = 1'b1;
      if (i == 133) begin
        arm     = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 9'd5;
      end
      tick();
      if (i == 133) begin
        arm   = 1'b0;
        rd_en = 1'b0;
        total_cnt++; if (rd_data !== 8'd144) $display("FAIL adc_read_first: got %0d want 144", rd_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL adc_busy: got %0b want 1", busy); else pass_cnt++;
      end
    end
    din_vld = 1'b0;
    total_cnt++; if (done !== 1'b1) $display("FAIL adc_done: got %0b want 1", done); else pass_cnt++;
    total_cnt++; if (period !== 16'd256 || period_vld !== 1'b1)
      $display("FAIL adc_period: got %0d/%0b want 256/1", period, period_vld); else pass_cnt++;
    read_word(0, d);
    total_cnt++; if (d !== 8'd128) $display("FAIL adc_addr0: got %0d want 128", d); else pass_cnt++;
    read_word(5, d);
    total_cnt++; if (d !== 8'd133) $display("FAIL adc_addr5: got %0d want 133", d); else pass_cnt++;
    read_word(511, d);
    total_cnt++; if (d !== 8'd127) $display("FAIL adc_addr511: got %0d want 127", d); else pass_cnt++;
  endtask

  initial begin
    rst        = 1'b0;
    din        = 8'd0;
    din_vld    = 1'b0;
    arm        = 1'b0;
    trig_level = 8'd0;
    trig_edge  = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = 9'd0;
    test_reset();
    test_sawtooth();
    test_falling();
    test_no_trigger();
    test_sparse();
    test_reset_mid();
    test_arm_during_capture();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 Parameter DW, default 8, sample width in bits.
REQ-002 Parameter AW, default 9, capture buffer address width (depth 2**AW = 512).
REQ-003 clk  input  1  the single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 din  input  DW  incoming waveform sample, unsigned.
REQ-006 din_vld  input  1  din is valid this cycle.
REQ-007 arm  input  1  single-cycle request to arm the trigger.
REQ-008 trig_level  input  DW  trigger threshold, unsigned.
REQ-009 trig_edge  input  1  0 = rising crossing, 1 = falling crossing.
REQ-010 busy  output  1  high in ARMED or CAPTURE.
REQ-011 done  output  1  high in DONE; buffer holds a complete capture.
REQ-012 rd_en  input  1  buffer read strobe.
REQ-013 rd_addr  input  AW  buffer read address.
REQ-014 rd_data  output  DW  read data, valid the cycle after rd_en.
REQ-015 wave_min  output  DW  minimum sample of the last capture.
REQ-016 wave_max  output  DW  maximum sample of the last capture.
REQ-017 period  output  16  valid-sample count between first and second trigger crossing.
REQ-018 period_vld  output  1  period holds a measured value.

Function
REQ-019 FSM states IDLE, ARMED, CAPTURE, DONE; IDLE -> ARMED on arm; ARMED -> CAPTURE on trigger; CAPTURE -> DONE after 2**AW samples written; DONE -> ARMED on arm.
REQ-020 arm in ARMED or CAPTURE is ignored; arm in DONE clears done, wave_min/max, period_vld, and the previous-sample register.
REQ-021 Rising trigger: din_vld with previous valid sample < trig_level and din >= trig_level; falling: previous >= trig_level and din < trig_level.
REQ-022 No trigger on the first valid sample after arming (previous-sample register invalid).
REQ-023 The triggering sample is written at address 0; each further din_vld in CAPTURE writes the next address; cycles without din_vld write nothing.
REQ-024 Write of address 2**AW-1 makes the FSM enter DONE on the next cycle; the write pointer does not wrap; samples in DONE/IDLE are not written.
REQ-025 wave_min/wave_max start from the trigger sample and update combinationally-free (registered) on every captured sample; final values are stable in DONE.
REQ-026 period counter starts at 1 on the trigger sample, increments per captured sample; on the next crossing of the same edge inside CAPTURE, period latches the count and period_vld sets; later crossings ignored.
REQ-027 If no second crossing occurs before DONE, period_vld stays 0 and period holds 0.
REQ-028 Period counter saturates at 16'hFFFF.
REQ-029 Reads are allowed in every state; read of the address written the same cycle returns the old contents (read-first).
REQ-030 trig_level and trig_edge are sampled every cycle; changing them in CAPTURE has no effect on capture.

Reset
REQ-031 rst forces IDLE, busy=0, done=0, wave_min=0, wave_max=0, period=0, period_vld=0, write pointer 0, previous-sample invalid.
REQ-032 rst mid-capture aborts the capture; buffer contents are not cleared; rd_data is undefined for one cycle after rst.

Structure
REQ-033 Shared package holds DW/AW defaults, buffer depth constant, period width, and FSM state encoding.
REQ-034 Buffer is one sub-module sample_ram: simple dual-port 2**AW x DW, one write port, one registered read port, read-first.

Verification
REQ-035 arm, rising sawtooth 0..255 step 1 every cycle, trig_level=128 -> address 0 = 128, address 511 = 127, done after 512 samples, min 0, max 255, period=256, period_vld=1.
REQ-036 Falling edge, square 0/200 half-period 32, trig_level=100 -> address 0 = 0, period=64, min 0, max 200.
REQ-037 Constant din=50, trig_level=50 -> no trigger, busy=1, done=0 indefinitely.
REQ-038 din_vld every third cycle during capture -> exactly 512 writes, done ~1536 cycles after trigger, contents match driven samples in order.
REQ-039 rst asserted at sample 300 of capture -> IDLE next cycle, all outputs 0; re-arm captures a fresh 512-sample buffer.
REQ-040 arm pulse during CAPTURE and read of address 5 while it is being written -> capture unaffected; rd_data returns previous contents.
